// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with a one-entry TX holding register.
// Ports: clk, rst (async active-low); sclk/mosi/ss_n (async SPI inputs);
//   miso (registered); tx_data/tx_valid/tx_ready (TX handshake);
//   rx_data/rx_valid (RX byte + strobe); busy; frame_err (abort pulse).
// Build option: SPI_SLAVE_MSB_FIRST_EN selects MSB-first bit order.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
    logic sclk_d, ss_d;
    logic sclk_s, mosi_s, ss_s;

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_nx, load_byte;
    logic [CW-1:0]         cnt;
    logic                  reload_pending;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic ev_start, ev_stop, ev_rise, ev_fall;
    logic consume, handshake;

    // ss_n chain resets high so release never fakes a falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q <= '0;
            mosi_q <= '0;
            ss_q   <= '1;
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign ss_s      = ss_q[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ss_fall) state_nx = ACTIVE;
            ACTIVE:  if (ss_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // output / event decode; ss_n edges mask any same-cycle SCLK edge
    always_comb begin
        busy     = (state == ACTIVE);
        ev_start = (state == IDLE) && ss_fall;
        ev_stop  = (state == ACTIVE) && ss_rise;
        ev_rise  = (state == ACTIVE) && !ss_rise && sclk_rise;
        ev_fall  = (state == ACTIVE) && !ss_rise && sclk_fall;
        consume  = ev_start || (ev_fall && reload_pending);
    end

    assign tx_ready  = ~hold_full;
    assign handshake = tx_valid & ~hold_full;
    assign load_byte = hold_full ? hold_data : '0;

`ifdef SPI_SLAVE_MSB_FIRST_EN
    assign rx_nx = {rx_sr[DATA_WIDTH-2:0], mosi_s};
`else
    assign rx_nx = {mosi_s, rx_sr[DATA_WIDTH-1:1]};
`endif

    // handshake only happens while empty, so a same-cycle consume
    // sends 0x00 and the new byte lands in the register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (handshake) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr          <= '0;
            rx_sr          <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_err      <= 1'b0;
            cnt            <= '0;
            reload_pending <= 1'b0;
            miso           <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (ev_stop) begin
                frame_err      <= (cnt != '0);
                cnt            <= '0;
                reload_pending <= 1'b0;
                rx_sr          <= '0;
                miso           <= 1'b0;
            end else if (ev_start) begin
                tx_sr <= load_byte;
                cnt   <= '0;
`ifdef SPI_SLAVE_MSB_FIRST_EN
                miso  <= load_byte[DATA_WIDTH-1];
`else
                miso  <= load_byte[0];
`endif
            end else if (ev_rise) begin
                rx_sr <= rx_nx;
                if (cnt == LAST) begin
                    rx_data        <= rx_nx;
                    rx_valid       <= 1'b1;
                    cnt            <= '0;
                    reload_pending <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (ev_fall) begin
                if (reload_pending) begin
                    tx_sr          <= load_byte;
                    reload_pending <= 1'b0;
`ifdef SPI_SLAVE_MSB_FIRST_EN
                    miso <= load_byte[DATA_WIDTH-1];
`else
                    miso <= load_byte[0];
`endif
                end else begin
`ifdef SPI_SLAVE_MSB_FIRST_EN
                    tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                    miso  <= tx_sr[DATA_WIDTH-2];
`else
                    tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
                    miso  <= tx_sr[1];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table vectors, hand sequences and random frames
// for spi_slave, checked against a byte-level queue model.
module tb_spi_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       miso, tx_ready, rx_valid, busy, frame_err;
    logic [7:0] rx_data;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int nv = 0;
    int ne = 0;

    always @(posedge clk) begin
        if (rx_valid)  nv++;
        if (frame_err) ne++;
    end

    logic [7:0] hq[$];
    logic [7:0] m_rx = '0;

    typedef struct {
        logic [15:0] mo;
        int          nb;
        bit          q0;
        logic [7:0]  t0;
        bit          q1;
        logic [7:0]  t1;
        logic [15:0] e_miso;
        logic [7:0]  e_rx;
        int          e_v;
        int          e_e;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pos(int i);
`ifdef SPI_SLAVE_MSB_FIRST_EN
        return (i / 8) * 8 + 7 - (i % 8);
`else
        return i;
`endif
    endfunction

    function automatic logic [7:0] take();
        if (hq.size() != 0) return hq.pop_front();
        return 8'h00;
    endfunction

    task automatic push(logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 100) begin
            cyc(1);
            t++;
        end
        if (!tx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_ready_timeout: got 0 expected 1");
            return;
        end
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        hq.push_back(d);
    endtask

    task automatic run_frame(
        input  logic [15:0] mo,
        input  int          nb,
        input  bit          q0,
        input  logic [7:0]  t0,
        input  bit          q1,
        input  logic [7:0]  t1,
        output logic [15:0] act,
        output logic [15:0] exp,
        output logic [15:0] mask,
        output logic        bsy
    );
        logic [7:0] cur;
        if (q0 && hq.size() == 0) push(t0);
        act  = '0;
        exp  = '0;
        mask = '0;
        bsy  = 1'b0;
        ss_n = 1'b0;
        cur  = take();
        exp[7:0] = cur;
        mosi = mo[pos(0)];
        cyc(HALF);
        for (int i = 0; i < nb; i++) begin
            if (i == 2 && q1) push(t1);
            if (i == 0) bsy = busy;
            act[pos(i)]  = miso;
            mask[pos(i)] = 1'b1;
            sclk = 1'b1;
            cyc(HALF);
            sclk = 1'b0;
            if (i % 8 == 7) begin
                m_rx = mo[(i / 8) * 8 +: 8];
                cur  = take();
                if (i == 7) exp[15:8] = cur;
            end
            if (i + 1 < nb) mosi = mo[pos(i + 1)];
            cyc(HALF);
        end
        ss_n = 1'b1;
        cyc(2 * HALF);
    endtask

    initial begin
        logic [15:0] act, exp, mask;
        logic        bsy;
        int          v0, e0;
        int          nb;
        bit          q0, q1;
        logic [15:0] mo;
        logic [7:0]  t0, t1;

        tbl[0] = '{16'h003C, 8,  1, 8'hA5, 0, 8'h00, 16'h00A5, 8'h3C, 1, 0};
        tbl[1] = '{16'h3412, 16, 1, 8'h11, 1, 8'h22, 16'h2211, 8'h34, 2, 0};
        tbl[2] = '{16'h00C3, 8,  0, 8'h00, 0, 8'h00, 16'h0000, 8'hC3, 1, 0};
        tbl[3] = '{16'h001F, 5,  0, 8'h00, 0, 8'h00, 16'h0000, 8'hC3, 0, 1};
        tbl[4] = '{16'h0096, 5,  1, 8'hA5, 0, 8'h00, 16'h00A5, 8'hC3, 0, 1};
        tbl[5] = '{16'h00FF, 8,  1, 8'hFF, 0, 8'h00, 16'h00FF, 8'hFF, 1, 0};

        cyc(3);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        cyc(4);

        foreach (tbl[k]) begin
            v0 = nv;
            e0 = ne;
            run_frame(tbl[k].mo, tbl[k].nb, tbl[k].q0, tbl[k].t0,
                      tbl[k].q1, tbl[k].t1, act, exp, mask, bsy);
            chk($sformatf("v%0d_miso", k), 32'(act & mask),
                32'(tbl[k].e_miso & mask));
            chk($sformatf("v%0d_rx", k), 32'(rx_data), 32'(tbl[k].e_rx));
            chk($sformatf("v%0d_nvalid", k), nv - v0, tbl[k].e_v);
            chk($sformatf("v%0d_nerr", k), ne - e0, tbl[k].e_e);
            chk($sformatf("v%0d_busy_mid", k), 32'(bsy), 1);
            chk($sformatf("v%0d_busy_end", k), 32'(busy), 0);
            chk($sformatf("v%0d_tx_ready", k), 32'(tx_ready), 1);
        end

        // reset in the middle of a frame with a byte held
        ss_n = 1'b0;
        mosi = 1'b1;
        cyc(HALF);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            cyc(HALF);
            sclk = 1'b0;
            cyc(HALF);
        end
        push(8'h66);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_tx_ready", 32'(tx_ready), 0);
        e0 = ne;
        rst = 1'b0;
        #1;
        chk("arst_miso", 32'(miso), 0);
        chk("arst_tx_ready", 32'(tx_ready), 1);
        chk("arst_rx_data", 32'(rx_data), 0);
        chk("arst_rx_valid", 32'(rx_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_frame_err", 32'(frame_err), 0);
        hq.delete();
        m_rx = '0;
        ss_n = 1'b1;
        mosi = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(4);
        chk("arst_no_err", ne - e0, 0);
        v0 = nv;
        run_frame(16'h005A, 8, 0, 8'h00, 0, 8'h00, act, exp, mask, bsy);
        chk("post_rst_rx", 32'(rx_data), 32'h5A);
        chk("post_rst_nvalid", nv - v0, 1);

        // random frames against the queue model
        for (int r = 0; r < 30; r++) begin
            nb = $urandom_range(1, 16);
            mo = 16'($urandom);
            t0 = 8'($urandom);
            t1 = 8'($urandom);
            q0 = 1'($urandom);
            q1 = 1'($urandom) && (nb > 2);
            v0 = nv;
            e0 = ne;
            run_frame(mo, nb, q0, t0, q1, t1, act, exp, mask, bsy);
            chk($sformatf("r%0d_miso", r), 32'(act & mask), 32'(exp & mask));
            chk($sformatf("r%0d_rx", r), 32'(rx_data), 32'(m_rx));
            chk($sformatf("r%0d_nvalid", r), nv - v0, nb / 8);
            chk($sformatf("r%0d_nerr", r), ne - e0, (nb % 8 != 0) ? 1 : 0);
            chk($sformatf("r%0d_busy", r), 32'(busy), 0);
            chk($sformatf("r%0d_tx_ready", r), 32'(tx_ready),
                (hq.size() == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
